// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Load-use interlock and EX/MEM/WB destination tracker that
//               feeds the forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  exmem_regwrite,
    output logic [REG_ADDR_W-1:0] exmem_rd,
    output logic                  memwb_regwrite,
    output logic [REG_ADDR_W-1:0] memwb_rd,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [0:0]       c_stRun   = 1'b0;
    localparam logic [0:0]       c_stStall = 1'b1;
    localparam logic [1:0]       c_cntInit = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] c_cntMax  = '1;
    localparam logic [CNT_W-1:0] c_cntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]            r_state;
    logic [1:0]            r_cnt;
    logic                  r_exRegwrite;
    logic                  r_exMemread;
    logic [REG_ADDR_W-1:0] r_exRd;
    logic                  r_memRegwrite;
    logic [REG_ADDR_W-1:0] r_memRd;
    logic                  r_wbRegwrite;
    logic [REG_ADDR_W-1:0] r_wbRd;
    logic [CNT_W-1:0]      r_stallCycles;

    logic w_hazard;
    logic w_stall;

    always_comb begin
        w_hazard = id_valid && r_exMemread && r_exRegwrite &&
                   ((r_exRd == id_rs) || (id_uses_rt && (r_exRd == id_rt)));
        // flush always wins: the squashed instruction must not hold the front end
        w_stall  = !flush && (((r_state == c_stRun) && w_hazard) || (r_state == c_stStall));
    end

    assign pc_write       = !w_stall;
    assign ifid_write     = !w_stall;
    assign idex_bubble    = w_stall || flush;
    assign exmem_regwrite = r_memRegwrite;
    assign exmem_rd       = r_memRd;
    assign memwb_regwrite = r_wbRegwrite;
    assign memwb_rd       = r_wbRd;
    assign stall_cycles   = r_stallCycles;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= c_stRun;
            r_cnt         <= '0;
            r_exRegwrite  <= 1'b0;
            r_exMemread   <= 1'b0;
            r_exRd        <= '0;
            r_memRegwrite <= 1'b0;
            r_memRd       <= '0;
            r_wbRegwrite  <= 1'b0;
            r_wbRd        <= '0;
            r_stallCycles <= '0;
        end else begin
            r_wbRegwrite  <= r_memRegwrite;
            r_wbRd        <= r_memRd;
            r_memRegwrite <= r_exRegwrite;
            r_memRd       <= r_exRd;

            if (w_stall || flush || !id_valid) begin
                r_exRegwrite <= 1'b0;
                r_exMemread  <= 1'b0;
                r_exRd       <= '0;
            end else begin
                // $0 is never a hazard or forwarding source
                r_exRegwrite <= id_regwrite && (id_rd != '0);
                r_exMemread  <= id_memread;
                r_exRd       <= id_rd;
            end

            if (w_stall && (r_stallCycles != c_cntMax)) begin
                r_stallCycles <= r_stallCycles + c_cntOne;
            end

            if (flush) begin
                r_state <= c_stRun;
                r_cnt   <= '0;
            end else if (r_state == c_stRun) begin
                // single-cycle latency needs no FSM: the load leaves EX after one bubble
                if (w_hazard && (LOAD_LAT > 1)) begin
                    r_state <= c_stStall;
                    r_cnt   <= c_cntInit;
                end
            end else begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    r_state <= c_stRun;
                end
            end
        end
    end

endmodule
`default_nettype wire
